// File: rtl/ft245_sync_device_if.sv
// ft245_sync_device_if: FT245 synchronous FIFO handshake strobes between host master and device
interface ft245_sync_device_if;
    logic rde_n;
    logic rd_n;
    logic oe_n;
    logic txe_n;
    logic wr_n;
    logic siwu;
    logic suspend_n;
    modport master (input rde_n, txe_n, suspend_n, output rd_n, oe_n, wr_n, siwu);
    modport slave (output rde_n, txe_n, suspend_n, input rd_n, oe_n, wr_n, siwu);
endinterface

// File: rtl/ft245_sync_device.sv
// ft245_sync_device: device-side FT245 synchronous FIFO emulation with RX/TX byte buffers
module ft245_sync_device #(
    parameter int RX_DEPTH_LOG2 = 6,
    parameter int TX_DEPTH_LOG2 = 6,
    parameter int TX_PKT        = 64,
    parameter int TX_GAP        = 4,
    parameter int RX_GAP        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] usb_in_data,
    input  logic       usb_in_last,
    input  logic       usb_in_valid,
    output logic       usb_in_ready,
    output logic [7:0] usb_out_data,
    output logic       usb_out_valid,
    input  logic       usb_out_ready,
    output logic       usb_out_flush,
    input  logic       usb_suspend,
    output logic       proto_err,
    inout  wire  [7:0] ftdi_data,
    ft245_sync_device_if.slave ftdi
);
    localparam int RXD = 1 << RX_DEPTH_LOG2;
    localparam int TXD = 1 << TX_DEPTH_LOG2;
    localparam int RCW = RX_DEPTH_LOG2 + 1;
    localparam int TCW = TX_DEPTH_LOG2 + 1;
    localparam int RGW = $clog2(RX_GAP + 1);
    localparam int TGW = $clog2(TX_GAP + 1);
    localparam int PKW = $clog2(TX_PKT + 1);

    typedef enum logic [1:0] {R_IDLE, R_AVAIL, R_GAP} rx_state_t;
    typedef enum logic {T_READY, T_GAP} tx_state_t;

    rx_state_t              rx_state;
    tx_state_t              tx_state;
    logic [8:0]             rx_mem [RXD];
    logic [7:0]             tx_mem [TXD];
    logic [RX_DEPTH_LOG2-1:0] rx_wr, rx_rd;
    logic [TX_DEPTH_LOG2-1:0] tx_wr, tx_rd;
    logic [RCW-1:0]         rx_count, rx_count_nx;
    logic [TCW-1:0]         tx_count, tx_count_nx;
    logic [RGW-1:0]         rx_gap;
    logic [TGW-1:0]         tx_gap;
    logic [PKW-1:0]         pkt_cnt;
    logic [8:0]             rx_head;
    logic                   rx_push, rx_pop, tx_push, tx_pop, tx_ok, tx_room, pkt_done;
    logic                   txe_d, siwu_d, err_now;

    assign rx_head       = rx_mem[rx_rd];
    assign ftdi_data     = ~ftdi.oe_n ? rx_head[7:0] : 8'hzz;
    assign rx_push       = usb_in_valid & usb_in_ready;
    assign rx_pop        = ~ftdi.rde_n & ~ftdi.rd_n & ~ftdi.oe_n;
    assign rx_count_nx   = rx_count + RCW'(rx_push) - RCW'(rx_pop);
    assign usb_out_valid = tx_count != '0;
    assign usb_out_data  = tx_mem[tx_rd];
    // A write one cycle after txe_n rose is the master's in-flight byte and is still taken
    assign tx_ok         = (~ftdi.txe_n | ~txe_d) & (tx_count != TCW'(TXD));
    assign tx_push       = ~ftdi.wr_n & ftdi.oe_n & tx_ok;
    assign tx_pop        = usb_out_valid & usb_out_ready;
    assign tx_count_nx   = tx_count + TCW'(tx_push) - TCW'(tx_pop);
    assign tx_room       = tx_count_nx <= TCW'(TXD - 2);
    assign pkt_done      = tx_push & (tx_state == T_READY) & (pkt_cnt == PKW'(TX_PKT - 1));
    assign err_now       = (~ftdi.rd_n & (ftdi.rde_n | ftdi.oe_n)) | (~ftdi.wr_n & (~ftdi.oe_n | ~tx_ok));

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr] <= {usb_in_last, usb_in_data};
        if (tx_push) tx_mem[tx_wr] <= ftdi_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state     <= R_IDLE;
            ftdi.rde_n   <= 1'b1;
            rx_gap       <= '0;
            rx_wr        <= '0;
            rx_rd        <= '0;
            rx_count     <= '0;
            usb_in_ready <= 1'b0;
        end else begin
            rx_count     <= rx_count_nx;
            usb_in_ready <= rx_count_nx != RCW'(RXD);
            rx_wr        <= rx_wr + RX_DEPTH_LOG2'(rx_push);
            rx_rd        <= rx_rd + RX_DEPTH_LOG2'(rx_pop);
            if (usb_suspend) begin
                rx_state   <= R_IDLE;
                ftdi.rde_n <= 1'b1;
                rx_gap     <= '0;
            end else begin
                case (rx_state)
                    R_IDLE: if (rx_count != '0) begin
                        rx_state   <= R_AVAIL;
                        ftdi.rde_n <= 1'b0;
                    end
                    R_AVAIL: if (rx_pop && rx_head[8]) begin
                        rx_state   <= R_GAP;
                        ftdi.rde_n <= 1'b1;
                        rx_gap     <= '0;
                    end else if (rx_count_nx == '0) begin
                        rx_state   <= R_IDLE;
                        ftdi.rde_n <= 1'b1;
                    end
                    default: begin
                        rx_state <= (rx_gap == RGW'(RX_GAP - 1)) ? R_IDLE : R_GAP;
                        rx_gap   <= (rx_gap == RGW'(RX_GAP - 1)) ? '0 : rx_gap + 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= T_READY;
            ftdi.txe_n <= 1'b1;
            txe_d      <= 1'b1;
            tx_gap     <= '0;
            pkt_cnt    <= '0;
            tx_wr      <= '0;
            tx_rd      <= '0;
            tx_count   <= '0;
        end else begin
            txe_d    <= ftdi.txe_n;
            tx_count <= tx_count_nx;
            tx_wr    <= tx_wr + TX_DEPTH_LOG2'(tx_push);
            tx_rd    <= tx_rd + TX_DEPTH_LOG2'(tx_pop);
            if (usb_suspend) begin
                tx_state   <= T_READY;
                ftdi.txe_n <= 1'b1;
                tx_gap     <= '0;
            end else if (tx_state == T_READY) begin
                tx_state   <= pkt_done ? T_GAP : T_READY;
                ftdi.txe_n <= pkt_done | ~tx_room;
                tx_gap     <= '0;
                pkt_cnt    <= pkt_done ? '0 : pkt_cnt + PKW'(tx_push);
            end else if (tx_gap == TGW'(TX_GAP - 1)) begin
                tx_state   <= T_READY;
                ftdi.txe_n <= ~tx_room;
                tx_gap     <= '0;
            end else begin
                tx_gap <= tx_gap + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            siwu_d         <= 1'b1;
            usb_out_flush  <= 1'b0;
            ftdi.suspend_n <= 1'b1;
            proto_err      <= 1'b0;
        end else begin
            siwu_d         <= ftdi.siwu;
            usb_out_flush  <= siwu_d & ~ftdi.siwu;
            ftdi.suspend_n <= ~usb_suspend;
            proto_err      <= proto_err | err_now;
        end
    end
endmodule
